// File: rtl/bp_counter_table.sv
// Branch predictor table of 2-bit counters. Lookup latency 1; updates commit 2 edges after the request.
// No backpressure: requests arriving while busy are dropped. Optional stats via BP_STATS_EN.
// Counters are swept to weak-not-taken after every reset.
module bp_counter_table #(
  parameter int LINES = 32,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             guess_valid,
  input  logic [IDX_W-1:0] guess_idx,
  output logic             guess_taken,
  output logic             guess_out_valid,
  input  logic             check_valid,
  input  logic [IDX_W-1:0] check_idx,
  input  logic             check_taken,
  input  logic             check_pred,
`ifdef BP_STATS_EN
  output logic [31:0]      stat_updates,
  output logic [31:0]      stat_mispredicts,
`endif
  output logic             busy
);

  localparam int AW = $clog2(LINES);
  localparam logic [AW-1:0] LAST = AW'(LINES - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] ptr;
  logic [1:0]    tbl [LINES];

  logic          p_vld;
  logic [AW-1:0] p_idx;
  logic          p_taken;
  logic [1:0]    p_new;

  logic [AW-1:0] gidx;
  logic [AW-1:0] cidx;
  logic          fwd;

  function automatic logic [1:0] next_ctr(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    nxt = cur;
    if (taken) begin
      case (cur)
        2'b00:   nxt = 2'b11;
        2'b01:   nxt = 2'b00;
        default: nxt = 2'b11;
      endcase
    end else begin
      case (cur)
        2'b11:   nxt = 2'b10;
        default: nxt = 2'b01;
      endcase
    end
    return nxt;
  endfunction

  assign gidx = guess_idx[AW-1:0];
  assign cidx = check_idx[AW-1:0];
  assign busy = (state == ST_INIT);

  // The write of stage P lands on the same edge the next update is captured,
  // so a following update to the same entry already reads the chained value.
  always_comb begin
    p_new = next_ctr(tbl[p_idx], p_taken);
    fwd   = p_vld && (p_idx == gidx);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else if (state == ST_INIT) begin
      ptr <= ptr + 1'b1;
      if (ptr == LAST) begin
        state <= ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == ST_INIT) begin
        tbl[ptr] <= 2'b00;
      end else if (p_vld) begin
        tbl[p_idx] <= p_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_vld   <= 1'b0;
      p_idx   <= '0;
      p_taken <= 1'b0;
    end else begin
      p_vld   <= (state == ST_RUN) && check_valid;
      p_idx   <= cidx;
      p_taken <= check_taken;
    end
  end

  // A same-cycle update is still only in flight, so the lookup sees the old value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      guess_out_valid <= 1'b0;
      guess_taken     <= 1'b0;
    end else begin
      guess_out_valid <= (state == ST_RUN) && guess_valid;
      if ((state == ST_RUN) && guess_valid) begin
        guess_taken <= fwd ? p_new[1] : tbl[gidx][1];
      end
    end
  end

`ifdef BP_STATS_EN
  logic p_mis;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_mis            <= 1'b0;
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else begin
      p_mis <= (check_pred != check_taken);
      if (p_vld) begin
        if (stat_updates != 32'hFFFF_FFFF) begin
          stat_updates <= stat_updates + 32'd1;
        end
        if (p_mis && (stat_mispredicts != 32'hFFFF_FFFF)) begin
          stat_mispredicts <= stat_mispredicts + 32'd1;
        end
      end
    end
  end
`else
  logic unused_pred;
  assign unused_pred = check_pred;
`endif

endmodule

// File: doc/bp_counter_table.md
BP_COUNTER_TABLE -- requirements
Module: bp_counter_table

Interface
REQ-001 SHALL have parameter LINES, default 32, number of 2-bit counter entries; must be a power of 2 and at least 2.
REQ-002 SHALL have parameter IDX_W, default $clog2(LINES), index width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port guess_valid, input, 1, prediction lookup request.
REQ-006 SHALL have port guess_idx, input, IDX_W, lookup index.
REQ-007 SHALL have port guess_taken, output, 1, registered prediction (counter MSB).
REQ-008 SHALL have port guess_out_valid, output, 1, marks guess_taken valid.
REQ-009 SHALL have port check_valid, input, 1, resolved-branch update request.
REQ-010 SHALL have port check_idx, input, IDX_W, update index.
REQ-011 SHALL have port check_taken, input, 1, resolved direction.
REQ-012 SHALL have port check_pred, input, 1, the prediction originally issued for this branch.
REQ-013 SHALL have port busy, output, 1, high while the table is initialising.

Function
REQ-014 Counter encoding SHALL be: 01 strong-NT, 00 weak-NT, 10 weak-T, 11 strong-T; prediction SHALL be the MSB.
REQ-015 The update rule SHALL be taken: 00->11, 01->00, 10->11, 11->11; not-taken: 00->01, 01->01, 10->01, 11->10.
REQ-016 FSM states SHALL be INIT and RUN; reset SHALL enter INIT with sweep pointer 0.
REQ-017 In INIT, the block SHALL write 00 to entry[pointer] each cycle and increment the pointer; after entry LINES-1 it SHALL move to RUN (LINES cycles total).
REQ-018 busy SHALL be 1 in INIT and 0 in RUN; requests during INIT SHALL be ignored (no output valid, no update).
REQ-019 Lookup: in RUN, guess_valid at edge N SHALL produce guess_out_valid=1 and guess_taken for the cycle after edge N (latency 1); guess_out_valid SHALL be 0 otherwise.
REQ-020 Update pipeline: stage P SHALL register check_idx/check_taken at edge N, and the entry SHALL be written with the updated value at edge N+1.
REQ-021 Forwarding: if a lookup index equals a valid stage-P index, guess_taken SHALL reflect the post-update value.
REQ-022 Back-to-back updates to the same index SHALL chain, so the second update operates on the first's result with no lost update.
REQ-023 A lookup and an update issued in the same cycle to the same index SHALL return the pre-update prediction.
REQ-024 Indices SHALL be taken modulo LINES; there are no out-of-range behaviours.

Reset
REQ-025 With rst_n=0 at an edge: guess_out_valid=0, guess_taken=0, busy=1, stage P invalid, state INIT, pointer 0.
REQ-026 Reset asserted mid-operation or mid-INIT SHALL discard pending updates and restart the full sweep.
REQ-027 Table contents SHALL be defined only by the sweep; no reset value is required on the array itself.

Configuration
REQ-028 Macro BP_STATS_EN SHALL add the outputs stat_updates[31:0] and stat_mispredicts[31:0].
REQ-029 With BP_STATS_EN defined, stat_updates SHALL count every accepted check_valid in RUN, and stat_mispredicts SHALL count those where check_pred!=check_taken.
REQ-030 Both counters SHALL saturate at 0xFFFFFFFF, reset to 0, and be updated one cycle after acceptance.
REQ-031 Without BP_STATS_EN, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-032 Reset then idle -> busy=1 for exactly LINES (32) cycles then 0; lookup of every index returns guess_taken=0.
REQ-033 Two taken updates to idx 5, then lookup idx 5 -> guess_taken=1 (00->11->11); one not-taken update -> 1 (11->10); another -> 0 (10->01).
REQ-034 Updates to idx 3 taken on consecutive cycles, followed by an immediate lookup -> forwarded guess_taken=1; a later not-taken update gives 10, confirming no lost update.
REQ-035 Same-cycle lookup+taken update on idx 7 (value 00) -> guess_taken=0; lookup on the next cycle -> 1.
REQ-036 Assert rst_n low at sweep pointer 10, and also with stage P valid -> sweep restarts at 0, busy=1 for 32 cycles, and the pending update is absent afterwards.
REQ-037 BP_STATS_EN: 4 updates with check_pred!=check_taken on 1 of them -> stat_updates=4, stat_mispredicts=1; updates issued during INIT are not counted.
